// File: rtl/segdisplay_decoder.sv
// Passive 7-segment bus monitor: rebuilds the 4 scanned characters and publishes them once stable.
// Build option SEGDECODE_HEX_EN: also decode the hex letter patterns A-F (codes 0x0A-0x0F).
module segdisplay_decoder #(
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        segclk,
  input  logic        clr,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [19:0] digits,
  output logic        valid,
  output logic        update,
  output logic        err,
  output logic        stale
);

  localparam int unsigned MW = $clog2(STABLE_FRAMES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [MW-1:0] MC_MAX = MW'(STABLE_FRAMES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  localparam logic [4:0] C_BLANK = 5'h10;
  localparam logic [4:0] C_BAD   = 5'h1F;

  typedef enum logic {COLLECT, CHECK} state_t;

  state_t          state;
  logic [6:0]      seg_q;
  logic [3:0]      an_q;
  logic [3:0]      seen;
  logic [3:0][4:0] cand;
  logic [3:0][4:0] prev;
  logic            prev_vld;
  logic [MW-1:0]   match_cnt;
  logic [TW-1:0]   tcnt;

  logic [3:0]      anl;
  logic [3:0]      slot_bit;
  logic [1:0]      slot_idx;
  logic            slot_wr;
  logic            multi;
  logic [3:0]      seen_base;
  logic [3:0]      seen_nxt;
  logic            frame_done;
  logic            eq;
  logic [MW-1:0]   match_nxt;
  logic            publish;

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] c;
    c = C_BAD;
    case (s)
      7'b1000000: c = 5'h00;
      7'b1111001: c = 5'h01;
      7'b0100100: c = 5'h02;
      7'b0110000: c = 5'h03;
      7'b0011001: c = 5'h04;
      7'b0010010: c = 5'h05;
      7'b0000010: c = 5'h06;
      7'b1111000: c = 5'h07;
      7'b0000000: c = 5'h08;
      7'b0010000: c = 5'h09;
      7'b1111111: c = C_BLANK;
`ifdef SEGDECODE_HEX_EN
      7'b0001000: c = 5'h0A;
      7'b0000011: c = 5'h0B;
      7'b1000110: c = 5'h0C;
      7'b0100001: c = 5'h0D;
      7'b0000110: c = 5'h0E;
      7'b0001110: c = 5'h0F;
`endif
      default:    c = C_BAD;
    endcase
    return c;
  endfunction

  always_comb begin
    anl      = ~an_q;
    slot_wr  = 1'b0;
    slot_idx = 2'd0;
    case (anl)
      4'b0001: begin slot_wr = 1'b1; slot_idx = 2'd0; end
      4'b0010: begin slot_wr = 1'b1; slot_idx = 2'd1; end
      4'b0100: begin slot_wr = 1'b1; slot_idx = 2'd2; end
      4'b1000: begin slot_wr = 1'b1; slot_idx = 2'd3; end
      default: ;
    endcase
    multi    = (anl != 4'b0000) && !slot_wr;
    slot_bit = slot_wr ? (4'b0001 << slot_idx) : 4'b0000;

    // CHECK clears seen first, so a digit landing that cycle starts the next frame
    seen_base  = (state == CHECK) ? 4'b0000 : seen;
    seen_nxt   = multi ? 4'b0000 : (seen_base | slot_bit);
    frame_done = (state == COLLECT) && slot_wr && ((seen | slot_bit) == 4'hF);

    eq = prev_vld && (cand == prev);
    if (!eq)
      match_nxt = '0;
    else if (match_cnt >= MC_MAX)
      match_nxt = MC_MAX;
    else
      match_nxt = match_cnt + 1'b1;
    publish = (match_nxt == MC_MAX) && (cand != digits);
  end

  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      state     <= COLLECT;
      seg_q     <= '1;
      an_q      <= '1;
      seen      <= '0;
      cand      <= '0;
      prev      <= '0;
      prev_vld  <= 1'b0;
      match_cnt <= '0;
      tcnt      <= '0;
      digits    <= {4{C_BLANK}};
      valid     <= 1'b0;
      update    <= 1'b0;
      err       <= 1'b0;
      stale     <= 1'b0;
    end else begin
      seg_q  <= seg;
      an_q   <= an;
      update <= 1'b0;
      seen   <= seen_nxt;
      if (slot_wr)
        cand[slot_idx] <= decode(seg_q);
      if (multi)
        err <= 1'b1;
      case (state)
        COLLECT: begin
          if (frame_done)
            state <= CHECK;
          if (tcnt != T_MAX)
            tcnt <= tcnt + 1'b1;
          if (tcnt == T_MAX - 1'b1) begin
            stale <= 1'b1;
            valid <= 1'b0;
          end
        end
        CHECK: begin
          match_cnt <= match_nxt;
          prev      <= cand;
          prev_vld  <= 1'b1;
          if (publish) begin
            digits <= cand;
            update <= 1'b1;
          end
          valid <= 1'b1;
          stale <= 1'b0;
          tcnt  <= '0;
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_segdisplay_decoder.sv
// Directed bench for segdisplay_decoder: reset, publish, glitch rejection, illegal anode, timeout, hex.
module tb_segdisplay_decoder;

  logic        segclk = 1'b0;
  logic        clr;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [19:0] digits;
  logic        valid;
  logic        update;
  logic        err;
  logic        stale;

  int unsigned tests   = 0;
  int unsigned fails   = 0;
  int unsigned upd_cnt = 0;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] PA    = 7'b0001000;
  localparam logic [6:0] PC    = 7'b1000110;

  localparam logic [19:0] D_BLANK = 20'h84210;
  localparam logic [19:0] D_1234  = 20'h08864;
  localparam logic [19:0] D_5678  = 20'h298E8;
`ifdef SEGDECODE_HEX_EN
  localparam logic [19:0] D_A0C0  = 20'h50180;
`else
  localparam logic [19:0] D_A0C0  = 20'hF83E0;
`endif

  segdisplay_decoder #(.STABLE_FRAMES(2), .TIMEOUT(1024)) dut (
    .segclk (segclk),
    .clr    (clr),
    .seg    (seg),
    .an     (an),
    .digits (digits),
    .valid  (valid),
    .update (update),
    .err    (err),
    .stale  (stale)
  );

  always #5 segclk = ~segclk;

  always @(negedge segclk) if (update === 1'b1) upd_cnt++;

  task automatic step(input logic [6:0] s, input logic [3:0] a);
    seg = s;
    an  = a;
    @(posedge segclk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(BLANK, 4'hF);
  endtask

  task automatic frame(input logic [6:0] p3, input logic [6:0] p2,
                       input logic [6:0] p1, input logic [6:0] p0);
    step(p3, 4'b0111);
    step(p2, 4'b1011);
    step(p1, 4'b1101);
    step(p0, 4'b1110);
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1;
    seg = BLANK;
    an  = 4'hF;
    repeat (2) @(posedge segclk);
    #1;
    chk("rst_digits", digits, D_BLANK);
    chk("rst_valid", 20'(valid), 20'd0);
    chk("rst_update", 20'(update), 20'd0);
    chk("rst_err", 20'(err), 20'd0);
    chk("rst_stale", 20'(stale), 20'd0);
    clr = 1'b0;

    // first frame after reset: valid but nothing published yet
    frame(pat[1], pat[2], pat[3], pat[4]);
    idle(2);
    chk("f1_valid", 20'(valid), 20'd1);
    chk("f1_digits", digits, D_BLANK);
    chk("f1_update", 20'(update), 20'd0);

    // reset mid-frame
    step(pat[9], 4'b0111);
    step(pat[9], 4'b1011);
    clr = 1'b1;
    #2;
    chk("midrst_digits", digits, D_BLANK);
    chk("midrst_valid", 20'(valid), 20'd0);
    chk("midrst_update", 20'(update), 20'd0);
    chk("midrst_err", 20'(err), 20'd0);
    chk("midrst_stale", 20'(stale), 20'd0);
    @(posedge segclk);
    #1;
    clr = 1'b0;
    step(pat[3], 4'b1101);
    step(pat[4], 4'b1110);
    idle(3);
    chk("partial_lost", 20'(valid), 20'd0);
    clr = 1'b1;
    #2;
    clr = 1'b0;

    // publish after two identical frames
    frame(pat[1], pat[2], pat[3], pat[4]);
    idle(2);
    chk("prev_lost_digits", digits, D_BLANK);
    chk("prev_lost_update", 20'(update), 20'd0);
    frame(pat[1], pat[2], pat[3], pat[4]);
    idle(2);
    chk("pub_update", 20'(update), 20'd1);
    chk("pub_digits", digits, D_1234);
    chk("pub_valid", 20'(valid), 20'd1);
    idle(1);
    chk("pub_update_fall", 20'(update), 20'd0);
    chk("pub_count", 20'(upd_cnt), 20'd1);

    // glitch rejection
    frame(pat[1], pat[2], pat[5], pat[4]);
    idle(2);
    chk("glitch_hold", digits, D_1234);
    frame(pat[1], pat[2], pat[3], pat[4]);
    frame(pat[1], pat[2], pat[3], pat[4]);
    idle(3);
    chk("glitch_count", 20'(upd_cnt), 20'd1);
    chk("glitch_digits", digits, D_1234);
    chk("glitch_valid", 20'(valid), 20'd1);

    // illegal anode pattern
    step(pat[5], 4'b0111);
    step(pat[6], 4'b1011);
    step(pat[7], 4'b0011);
    chk("err_latency", 20'(err), 20'd0);
    idle(1);
    chk("err_set", 20'(err), 20'd1);
    frame(pat[5], pat[6], pat[7], pat[8]);
    frame(pat[5], pat[6], pat[7], pat[8]);
    idle(2);
    chk("err_pub_update", 20'(update), 20'd1);
    chk("err_pub_digits", digits, D_5678);
    chk("err_sticky", 20'(err), 20'd1);
    idle(1);
    chk("err_pub_count", 20'(upd_cnt), 20'd2);

    // timeout: last CHECK was 1 edge ago
    idle(1022);
    chk("pre_to_stale", 20'(stale), 20'd0);
    chk("pre_to_valid", 20'(valid), 20'd1);
    idle(1);
    chk("to_stale", 20'(stale), 20'd1);
    chk("to_valid", 20'(valid), 20'd0);
    chk("to_digits", digits, D_5678);
    frame(pat[5], pat[6], pat[7], pat[8]);
    frame(pat[5], pat[6], pat[7], pat[8]);
    idle(2);
    chk("rec_stale", 20'(stale), 20'd0);
    chk("rec_valid", 20'(valid), 20'd1);
    chk("rec_digits", digits, D_5678);
    idle(1);
    chk("rec_count", 20'(upd_cnt), 20'd2);

    // hex letters, decoded or rejected depending on build
    frame(PA, pat[0], PC, pat[0]);
    frame(PA, pat[0], PC, pat[0]);
    idle(2);
    chk("hex_update", 20'(update), 20'd1);
    chk("hex_digits", digits, D_A0C0);
    idle(1);
    chk("hex_err_sticky", 20'(err), 20'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/segdisplay_decoder.md
# segdisplay_decoder

Passive monitor that sits on the multiplexed 7-segment bus (`seg`/`an`) driven by the display scanner and reconstructs the four displayed characters. Each scanned digit is decoded back to a character code, assembled into a 4-digit frame, and confirmed only after it repeats for a configurable number of consecutive frames. It is used for on-board self-test and score readback, and raises error and stale flags when the bus misbehaves.

## Interface
- `STABLE_FRAMES`, 2: number of consecutive identical complete frames required before the frame is published (≥1).
- `TIMEOUT`, 1024: `segclk` cycles without a completed frame before `stale` asserts (≥8).
- `segclk`  in  1  scan clock; the same clock that drives the display scanner.
- `clr`  in  1  reset; one clock domain, asynchronous, active-high.
- `seg`  in  7  segment bus, active-low, bit order {g,f,e,d,c,b,a} = seg[6:0].
- `an`  in  4  anode enables, active-low; an[3] = leftmost digit.
- `digits`  out  20  published frame as four 5-bit codes; [19:15] = leftmost digit.
- `valid`  out  1  high while `digits` holds a confirmed, non-stale frame.
- `update`  out  1  one-cycle pulse when `digits` takes a new value.
- `err`  out  1  sticky; set on an illegal anode pattern, cleared only by `clr`.
- `stale`  out  1  set when no frame completes within `TIMEOUT` cycles.

## Operation
- **Codes:** 0x00–0x09 are the digits 0–9; 0x0A–0x0F are hex A–F (only when the hex macro is defined); 0x10 is blank; 0x1F is unrecognised.
- **Digit patterns (gfedcba):** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111. Any other pattern decodes to 0x1F.
- **Input stage:** `seg` and `an` are registered once (`seg_q`, `an_q`).
- **Slot capture:**
  - `an_q` with exactly one bit low: write the decoded code into that slot's candidate register and set that slot's seen bit.
  - `an_q` == 1111: idle cycle, no action.
  - Two or more bits low: set `err`, clear all seen bits (the partial frame is discarded), write nothing.
  - The same slot arriving again before the frame completes overwrites that slot. No error.
- **FSM:**
  - COLLECT: stays in COLLECT until the write that makes seen == 1111, then moves to CHECK.
  - CHECK (one cycle):
    - Compare the candidate with the previous complete frame. If equal, `match_cnt` = min(`match_cnt`+1, `STABLE_FRAMES`-1); if not, `match_cnt` = 0.
    - Save the candidate as the previous frame.
    - Clear the seen bits. A slot write arriving in the same cycle is applied after the clear and counts toward the next frame.
    - Publish when `match_cnt` reaches `STABLE_FRAMES`-1 (counting the current frame) and the candidate ≠ `digits`: load `digits` and pulse `update`.
    - Set `valid` = 1 and `stale` = 0.
    - Return to COLLECT.
- **Timeout:**
  - A counter is zeroed at every CHECK and otherwise increments, saturating at `TIMEOUT`.
  - When it reaches `TIMEOUT`: `stale` = 1 and `valid` = 0. `digits` is held.
- **Counter widths:** `$clog2(TIMEOUT+1)` for the timeout counter, `$clog2(STABLE_FRAMES+1)` for `match_cnt`.
- **Reset mid-frame:** all state discarded immediately, including the candidate, the previous frame, and the seen bits.

## Timing
- **Reset values:** `digits` = {4{5'h10}}, `valid` = 0, `update` = 0, `err` = 0, `stale` = 0, FSM = COLLECT, seen = 0000, all counters = 0.
- **Latency:** the last digit of a frame on the pins at edge N gives CHECK at edge N+2. `digits`, `update` and `valid` are visible after edge N+2, i.e. 3 edges from pin to output.
- **`update`:** exactly one cycle wide.
- **`err`:** asserts after edge N+1 for an illegal `an` sampled at edge N.
- **Throughput:** sustains one digit per `segclk` with no gaps. One frame every 4 cycles is the nominal rate.

## Configuration
- **`SEGDECODE_HEX_EN`**
  - Defined: the patterns A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 decode to 0x0A–0x0F.
  - Undefined: those patterns decode to 0x1F.
  - Digits 0–9, blank and all other logic are identical in both builds.

## Test plan
- **Reset values:** assert `clr` mid-frame → `digits` = 0x84210 ({4{5'h10}}), `valid` = `update` = `err` = `stale` = 0 on the next cycle, and the partial frame is lost.
- **Publish after two frames:** scan "1234" (an 0111→1011→1101→1110) twice with `STABLE_FRAMES` = 2 → one `update` pulse 3 edges after the 8th digit, `digits` = {5'd1,5'd2,5'd3,5'd4}, `valid` = 1.
- **Glitch rejection:** scan "1234", then "1254" once, then "1234" twice → no `update` for "1254" and no second `update` for "1234" (value unchanged). `digits` stays 1234.
- **Illegal anode:** drive an = 0011 mid-frame → `err` = 1 one edge later and stays set; the next two clean "5678" frames publish 5678.
- **Timeout:** hold an = 1111 for 1024 cycles after a valid frame → `stale` = 1, `valid` = 0, `digits` held. The next two complete frames clear `stale`.
- **Hex decode:** scan "A0C0" (seg 0001000, 1000000, 1000110, 1000000) twice → with `SEGDECODE_HEX_EN`, `digits` = {0x0A,0x00,0x0C,0x00}; without it, {0x1F,0x00,0x1F,0x00}.
